// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac
// Fractional baud-rate generator feeding the UART RX/TX FSMs. It produces an
// oversample strobe (sample_tick) and a per-bit strobe (bit_tick) from a
// run-time loadable {integer, fraction} divisor.
// The divisor is double-buffered: div_load writes a shadow copy. The shadow
// becomes active only at a tick boundary, while the generator is disabled,
// or on sync. A tick period is therefore never split.
// Build option: define BAUD_FRAC_EN to include the fractional accumulator.
// Without it, div_frac is ignored and every period is max(div_int,1) cycles.
module uart_baud_gen_frac #(
  parameter int SYS_FREQ   = 100000000,
  parameter int BAUD_RATE  = 38400,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    div_load,
  input  logic [DIV_W-1:0]        div_int,
  input  logic [FRAC_W-1:0]       div_frac,
  input  logic                    sync,
  output logic                    sample_tick,
  output logic                    bit_tick,
  output logic [DIV_W+FRAC_W-1:0] div_active
);

  localparam int PH_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [63:0] DEN        = 64'(BAUD_RATE) * 64'(OVERSAMPLE);
  localparam logic [63:0] DEF_INT_L  = 64'(SYS_FREQ) / DEN;
  localparam logic [DIV_W-1:0] DEF_INT_RAW = DEF_INT_L[DIV_W-1:0];
  // A zero divisor would never wrap, so it is clamped to one cycle.
  localparam logic [DIV_W-1:0] DEF_INT =
      (DEF_INT_RAW == {DIV_W{1'b0}}) ? {{(DIV_W-1){1'b0}}, 1'b1} : DEF_INT_RAW;
  localparam logic [DIV_W:0]   ONE_W   = {{DIV_W{1'b0}}, 1'b1};
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0]  PH_ONE  = {{(PH_W-1){1'b0}}, 1'b1};

  logic [DIV_W:0]    cnt_r;
  logic [DIV_W:0]    lim_s;
  logic [PH_W-1:0]   phase_r;
  logic [DIV_W-1:0]  int_active_r;
  logic [DIV_W-1:0]  int_shadow_r;
  logic [DIV_W-1:0]  int_load_s;
  logic              pend_r;
  logic              wrap_s;
  logic              apply_s;
  logic              carry_s;

`ifdef BAUD_FRAC_EN
  localparam logic [63:0] DEF_FRAC_L =
      ((64'(SYS_FREQ) << FRAC_W) / DEN) % (64'd1 << FRAC_W);
  localparam logic [FRAC_W-1:0] DEF_FRAC = DEF_FRAC_L[FRAC_W-1:0];

  logic [FRAC_W-1:0] acc_r;
  logic [FRAC_W-1:0] frac_active_r;
  logic [FRAC_W-1:0] frac_shadow_r;
  logic [FRAC_W:0]   acc_sum_s;

  // Fractional accumulator sum; its MSB lengthens the current period by one cycle.
  always_comb begin
    acc_sum_s = {1'b0, acc_r} + {1'b0, frac_active_r};
    carry_s   = acc_sum_s[FRAC_W];
  end
`else
  logic frac_unused_s;
  assign frac_unused_s = ^div_frac;
  assign carry_s       = 1'b0;
`endif

  // Period limit, wrap detection and divisor apply point.
  always_comb begin
    lim_s = {1'b0, int_active_r} - ONE_W + {{DIV_W{1'b0}}, carry_s};
    if (div_int == {DIV_W{1'b0}}) begin
      int_load_s = {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      int_load_s = div_int;
    end
    // >= rather than == so that a smaller divisor applied while cnt is held
    // (enable low) still wraps at once instead of running away.
    wrap_s  = enable && !sync && (cnt_r >= lim_s);
    apply_s = wrap_s || !enable || sync;
  end

  // Tick counter, bit phase and the registered strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r       <= {(DIV_W+1){1'b0}};
      phase_r     <= {PH_W{1'b0}};
      sample_tick <= 1'b0;
      bit_tick    <= 1'b0;
    end else if (sync) begin
      cnt_r       <= {(DIV_W+1){1'b0}};
      phase_r     <= {PH_W{1'b0}};
      sample_tick <= 1'b0;
      bit_tick    <= 1'b0;
    end else if (wrap_s) begin
      cnt_r       <= {(DIV_W+1){1'b0}};
      sample_tick <= 1'b1;
      bit_tick    <= (phase_r == PH_LAST);
      phase_r     <= (phase_r == PH_LAST) ? {PH_W{1'b0}} : phase_r + PH_ONE;
    end else if (enable) begin
      cnt_r       <= cnt_r + ONE_W;
      sample_tick <= 1'b0;
      bit_tick    <= 1'b0;
    end else begin
      sample_tick <= 1'b0;
      bit_tick    <= 1'b0;
    end
  end

  // Integer divisor: shadow capture, pending flag and apply to active.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_active_r <= DEF_INT;
      int_shadow_r <= DEF_INT;
      pend_r       <= 1'b0;
    end else if (div_load) begin
      int_shadow_r <= int_load_s;
      if (apply_s) begin
        int_active_r <= int_load_s;
        pend_r       <= 1'b0;
      end else begin
        pend_r       <= 1'b1;
      end
    end else if (apply_s && pend_r) begin
      int_active_r <= int_shadow_r;
      pend_r       <= 1'b0;
    end
  end

`ifdef BAUD_FRAC_EN
  // Fractional divisor registers (same apply rules as the integer part) and the accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frac_active_r <= DEF_FRAC;
      frac_shadow_r <= DEF_FRAC;
      acc_r         <= {FRAC_W{1'b0}};
    end else begin
      if (wrap_s) begin
        acc_r <= acc_sum_s[FRAC_W-1:0];
      end
      if (div_load) begin
        frac_shadow_r <= div_frac;
        if (apply_s) begin
          frac_active_r <= div_frac;
        end
      end else if (apply_s && pend_r) begin
        frac_active_r <= frac_shadow_r;
      end
    end
  end

  assign div_active = {int_active_r, frac_active_r};
`else
  assign div_active = {int_active_r, {FRAC_W{1'b0}}};
`endif

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac (default parameters). Expected values
// follow the BAUD_FRAC_EN setting of the build.
module tb_uart_baud_gen_frac;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        div_load;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        sync;
  logic        sample_tick;
  logic        bit_tick;
  logic [19:0] div_active;

  int checks = 0;
  int errors = 0;

`ifdef BAUD_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif
  localparam logic [19:0] DEF_ACT = FRAC_ON ? {16'd162, 4'd12} : {16'd162, 4'd0};

  uart_baud_gen_frac dut (
    .clk(clk), .reset(reset), .enable(enable), .div_load(div_load),
    .div_int(div_int), .div_frac(div_frac), .sync(sync),
    .sample_tick(sample_tick), .bit_tick(bit_tick), .div_active(div_active)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Count negedges until sample_tick is seen; -1 on timeout.
  task automatic wait_tick(input int max_cyc, output int cyc);
    bit found = 1'b0;
    cyc = -1;
    for (int i = 1; i <= max_cyc && !found; i++) begin
      @(negedge clk);
      if (sample_tick === 1'b1) begin
        cyc = i;
        found = 1'b1;
      end
    end
  endtask

  // Count negedges until bit_tick is seen; -1 on timeout.
  task automatic wait_bit(input int max_cyc, output int cyc);
    bit found = 1'b0;
    cyc = -1;
    for (int i = 1; i <= max_cyc && !found; i++) begin
      @(negedge clk);
      if (bit_tick === 1'b1) begin
        cyc = i;
        found = 1'b1;
      end
    end
  endtask

  // div_load together with sync: new divisor goes straight to active.
  task automatic load_sync(input logic [15:0] di, input logic [3:0] df);
    div_int  = di;
    div_frac = df;
    div_load = 1'b1;
    sync     = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    sync     = 1'b0;
  endtask

  task automatic test_reset();
    int c;
    int total = 0;
    int early_bits = 0;
    reset = 1'b1; enable = 1'b1; div_load = 1'b0; sync = 1'b0;
    div_int = 16'd0; div_frac = 4'd0;
    repeat (3) @(negedge clk);
    checks++; if (sample_tick !== 1'b0) begin errors++; $display("FAIL reset_sample_tick: got %b expected 0", sample_tick); end
    checks++; if (bit_tick !== 1'b0) begin errors++; $display("FAIL reset_bit_tick: got %b expected 0", bit_tick); end
    checks++; if (div_active !== DEF_ACT) begin errors++; $display("FAIL reset_div_active: got %h expected %h", div_active, DEF_ACT); end
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      wait_tick(400, c);
      total += c;
      if (k == 1) begin
        checks++; if (c != 162) begin errors++; $display("FAIL reset_first_period: got %0d expected 162", c); end
      end
      if (k < 16 && bit_tick !== 1'b0) early_bits++;
      if (k == 16) begin
        checks++; if (bit_tick !== 1'b1) begin errors++; $display("FAIL reset_bit_on_16th: got %b expected 1", bit_tick); end
      end
    end
    checks++; if (early_bits != 0) begin errors++; $display("FAIL reset_early_bit_ticks: got %0d expected 0", early_bits); end
    checks++; if (total != (FRAC_ON ? 2604 : 2592)) begin errors++; $display("FAIL reset_16_tick_total: got %0d expected %0d", total, FRAC_ON ? 2604 : 2592); end
  endtask

  task automatic test_div_load();
    int c;
    div_int = 16'd4; div_frac = 4'd0; div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    checks++; if (div_active !== DEF_ACT) begin errors++; $display("FAIL load_pending_active: got %h expected %h", div_active, DEF_ACT); end
    wait_tick(400, c);
    checks++; if (c + 1 != 162) begin errors++; $display("FAIL load_old_period: got %0d expected 162", c + 1); end
    checks++; if (div_active !== {16'd4, 4'd0}) begin errors++; $display("FAIL load_applied_active: got %h expected %h", div_active, {16'd4, 4'd0}); end
    for (int k = 0; k < 3; k++) begin
      wait_tick(20, c);
      checks++; if (c != 4) begin errors++; $display("FAIL load_period4_%0d: got %0d expected 4", k, c); end
    end
    wait_bit(200, c);
    wait_bit(200, c);
    checks++; if (c != 64) begin errors++; $display("FAIL load_bit_period: got %0d expected 64", c); end
  endtask

  task automatic test_frac();
    int p1, p2, p3, p4;
    load_sync(16'd4, 4'd8);
    checks++; if (sample_tick !== 1'b0) begin errors++; $display("FAIL frac_sync_suppress: got %b expected 0", sample_tick); end
    checks++; if (div_active !== (FRAC_ON ? {16'd4, 4'd8} : {16'd4, 4'd0})) begin errors++; $display("FAIL frac_div_active: got %h", div_active); end
    wait_tick(20, p1); wait_tick(20, p2); wait_tick(20, p3); wait_tick(20, p4);
    checks++; if (p1 + p2 != (FRAC_ON ? 9 : 8)) begin errors++; $display("FAIL frac_pair_sum: got %0d expected %0d", p1 + p2, FRAC_ON ? 9 : 8); end
    checks++; if (p1 < 4 || p1 > (FRAC_ON ? 5 : 4)) begin errors++; $display("FAIL frac_period_range: got %0d expected 4..%0d", p1, FRAC_ON ? 5 : 4); end
    checks++; if (p3 != p1) begin errors++; $display("FAIL frac_alternate_a: got %0d expected %0d", p3, p1); end
    checks++; if (p4 != p2) begin errors++; $display("FAIL frac_alternate_b: got %0d expected %0d", p4, p2); end
  endtask

  task automatic test_div0();
    int misses = 0;
    int bitbad = 0;
    load_sync(16'd0, 4'd0);
    checks++; if (div_active !== {16'd1, 4'd0}) begin errors++; $display("FAIL div0_active: got %h expected %h", div_active, {16'd1, 4'd0}); end
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (sample_tick !== 1'b1) misses++;
      if (bit_tick !== (i == 16)) bitbad++;
    end
    checks++; if (misses != 0) begin errors++; $display("FAIL div0_every_cycle: got %0d missed ticks expected 0", misses); end
    checks++; if (bitbad != 0) begin errors++; $display("FAIL div0_bit_tick: got %0d wrong cycles expected 0", bitbad); end
  endtask

  task automatic test_sync();
    int c, first, n, badp;
    load_sync(16'd4, 4'd0);
    wait_tick(20, c);
    checks++; if (c != 4) begin errors++; $display("FAIL sync_load_first: got %0d expected 4", c); end
    wait_tick(20, c);
    repeat (2) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    checks++; if (sample_tick !== 1'b0 || bit_tick !== 1'b0) begin errors++; $display("FAIL sync_mid_suppress: got %b%b expected 00", sample_tick, bit_tick); end
    n = 0; badp = 0; first = -1;
    for (int k = 0; k < 20; k++) begin
      wait_tick(20, c);
      if (k == 0) first = c;
      n++;
      if (c != 4) badp++;
      if (bit_tick === 1'b1) break;
    end
    checks++; if (first != 4) begin errors++; $display("FAIL sync_next_tick: got %0d expected 4", first); end
    checks++; if (n != 16) begin errors++; $display("FAIL sync_bit_after_16: got %0d expected 16", n); end
    checks++; if (badp != 0) begin errors++; $display("FAIL sync_periods: got %0d bad expected 0", badp); end
    repeat (3) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    checks++; if (sample_tick !== 1'b0) begin errors++; $display("FAIL sync_on_wrap_suppress: got %b expected 0", sample_tick); end
    wait_tick(20, c);
    checks++; if (c != 4) begin errors++; $display("FAIL sync_on_wrap_next: got %0d expected 4", c); end
  endtask

  task automatic test_enable();
    int c;
    int first = -1;
    int lowticks = 0;
    load_sync(16'd8, 4'd0);
    wait_tick(20, c);
    checks++; if (c != 8) begin errors++; $display("FAIL en_period8: got %0d expected 8", c); end
    for (int i = 1; i <= 30 && first < 0; i++) begin
      @(negedge clk);
      if (i >= 4 && i <= 13 && sample_tick !== 1'b0) lowticks++;
      if (sample_tick === 1'b1) first = i;
      if (i == 3) enable = 1'b0;
      if (i == 13) enable = 1'b1;
    end
    enable = 1'b1;
    checks++; if (lowticks != 0) begin errors++; $display("FAIL en_low_ticks: got %0d expected 0", lowticks); end
    checks++; if (first != 18) begin errors++; $display("FAIL en_resume_period: got %0d expected 18", first); end
    @(negedge clk);
    div_int = 16'd6; div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0; enable = 1'b0;
    checks++; if (div_active !== {16'd8, 4'd0}) begin errors++; $display("FAIL en_pending_active: got %h expected %h", div_active, {16'd8, 4'd0}); end
    lowticks = 0;
    for (int i = 3; i <= 12; i++) begin
      @(negedge clk);
      if (sample_tick !== 1'b0) lowticks++;
      if (i == 3) begin
        checks++; if (div_active !== {16'd6, 4'd0}) begin errors++; $display("FAIL en_low_apply: got %h expected %h", div_active, {16'd6, 4'd0}); end
      end
    end
    enable = 1'b1;
    checks++; if (lowticks != 0) begin errors++; $display("FAIL en_low_ticks2: got %0d expected 0", lowticks); end
    wait_tick(20, c);
    checks++; if (c != 4) begin errors++; $display("FAIL en_resume_new_lim: got %0d expected 4", c); end
    wait_tick(20, c);
    checks++; if (c != 6) begin errors++; $display("FAIL en_period6: got %0d expected 6", c); end
  endtask

  task automatic test_reset_mid();
    int c;
    load_sync(16'd0, 4'd0);
    @(negedge clk);
    checks++; if (sample_tick !== 1'b1) begin errors++; $display("FAIL rmid_tick_before: got %b expected 1", sample_tick); end
    #2 reset = 1'b1;
    #1;
    checks++; if (sample_tick !== 1'b0 || bit_tick !== 1'b0) begin errors++; $display("FAIL rmid_async_drop: got %b%b expected 00", sample_tick, bit_tick); end
    checks++; if (div_active !== DEF_ACT) begin errors++; $display("FAIL rmid_div_active: got %h expected %h", div_active, DEF_ACT); end
    @(negedge clk);
    reset = 1'b0;
    wait_tick(400, c);
    checks++; if (c != 162) begin errors++; $display("FAIL rmid_first_period: got %0d expected 162", c); end
  endtask

  initial begin
    test_reset();
    test_div_load();
    test_frac();
    test_div0();
    test_sync();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen_frac.md
# uart_baud_gen_frac

Programmable fractional baud-rate generator for the UART receiver and transmitter. It replaces the fixed-divisor tick generator with a run-time loadable integer+fractional divisor, a configurable oversampling factor, a derived per-bit tick, and a phase resync input for receiver start-bit alignment. It sits between the system clock domain and both UART FSMs, and drives their oversample and bit-strobe inputs.

## Interface
- SYS_FREQ, 100000000: system clock frequency in Hz; used only for the reset divisor.
- BAUD_RATE, 38400: reset-default baud rate.
- OVERSAMPLE, 16: sample ticks per bit; legal range 2..64.
- DIV_W, 16: integer divisor width.
- FRAC_W, 4: fractional divisor width, in 1/2^FRAC_W units.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clock clk.
- enable  in  1  run the generator. While low, counters hold and ticks are 0.
- div_load  in  1  one-cycle strobe that captures div_int/div_frac into the shadow registers.
- div_int  in  DIV_W  integer part of the cycles-per-sample-tick value.
- div_frac  in  FRAC_W  fractional part of the cycles-per-sample-tick value.
- sync  in  1  restarts tick phase; the receiver pulses this on the start-bit falling edge.
- sample_tick  out  1  registered one-cycle oversample strobe.
- bit_tick  out  1  registered one-cycle strobe, coincident with every OVERSAMPLE-th sample_tick.
- div_active  out  DIV_W+FRAC_W  divisor currently in use, as {int, frac}.

## Operation
- Reset defaults:
  - DEF_INT = SYS_FREQ/(BAUD_RATE*OVERSAMPLE), floor; 162 for the default parameters.
  - DEF_FRAC = (SYS_FREQ*2^FRAC_W/(BAUD_RATE*OVERSAMPLE)) mod 2^FRAC_W; 12 for the default parameters.
- Reset state:
  - Active divisor = {DEF_INT, DEF_FRAC}; the shadow registers hold the same value.
  - cnt = 0, acc = 0, phase = 0, pend = 0.
  - sample_tick = 0, bit_tick = 0.
- An effective div_int of 0 is treated as 1. div_active reports the clamped value.
- Per enabled cycle:
  - carry = MSB of (acc + frac_active), computed in FRAC_W+1 bits.
  - lim = int_active - 1 + carry, computed in DIV_W+1 bits with no overflow.
  - If cnt == lim: cnt <= 0, acc <= (acc + frac_active) mod 2^FRAC_W, sample_tick <= 1.
  - Otherwise: cnt <= cnt + 1, sample_tick <= 0.
- Average sample period = div_int + div_frac/2^FRAC_W cycles. Individual periods are either div_int or div_int+1.
- Bit tick:
  - phase increments on every sample_tick and wraps from OVERSAMPLE-1 to 0.
  - bit_tick <= 1 in the same cycle sample_tick <= 1 when phase == OVERSAMPLE-1.
- Divisor load:
  - div_load sets pend and captures the shadow registers. A later div_load before the apply point overwrites the shadow.
  - The shadow is applied (active <= shadow, pend <= 0) at the first of these events: a cnt wrap, enable low, or sync. A tick period is never split.
  - div_load and an apply event in the same cycle: the new inputs go directly to active.
- sync:
  - cnt <= 0 and phase <= 0. acc is kept.
  - Suppresses sample_tick and bit_tick for that cycle.
  - Priority: reset > sync > enable.
- enable low: cnt, acc and phase hold; outputs are 0. On re-enable, counting resumes from the held cnt.

## Timing
- sample_tick is registered. With div_int = N and frac = 0, the first tick is in cycle N after reset release or sync (cycle 1 is the first edge), then every N cycles.
- bit_tick period = OVERSAMPLE × the sample period. The first bit_tick after sync is the OVERSAMPLE-th sample_tick.
- div_active updates on the clock edge of the apply event and is visible the cycle after.
- Reset mid-period: all state returns to defaults immediately. The outputs drop asynchronously.

## Configuration
- BAUD_FRAC_EN defined: the fractional accumulator is present, and div_frac and DEF_FRAC are used as described above.
- BAUD_FRAC_EN undefined:
  - acc, carry and the frac shadow/active registers are removed.
  - div_frac is ignored and the frac field of div_active reads 0.
  - Periods are exactly max(div_int, 1) cycles.

## Test plan
- Reset with defaults and frac enabled: the first sample_tick comes after 162 or 163 cycles. Over 16 ticks the total is 162×16+12 = 2604 cycles. bit_tick is on the 16th tick.
- div_load div_int=4, div_frac=0: after the current period ends, sample_tick is every 4 cycles and bit_tick every 64 cycles.
- div_int=4, div_frac=8 (FRAC_W=4): periods alternate 4,5,4,5. Without BAUD_FRAC_EN, the period is a constant 4.
- div_int=0: a sample_tick on every cycle and div_active int field = 1.
- Pulse sync mid-bit with div_int=4: no tick in the sync cycle, the next sample_tick 4 cycles later, and bit_tick after 16 sample ticks.
- Drop enable for 10 cycles mid-period: no ticks while low. The remaining period resumes unchanged, and a pending div_load applies during the low window.
